// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the 8:1 channel-select scanner.
// Used by mux_sel_scanner and mux_sel_next_pick.
package mux_sel_pkg;

   localparam int SEL_W  = 3;
   localparam int NUM_CH = 8;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [NUM_CH-1:0] ch_mask_t;

   localparam logic MODE_AUTO   = 1'b0;
   localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/mux_sel_next_pick.sv
// Next eligible channel: rotate the mask so the search origin is bit 0,
// then priority-encode. Optional dir port with MUX_SEL_SCANNER_REVERSE_EN.
module mux_sel_next_pick
   import mux_sel_pkg::*;
(
   input  sel_t     cur_i,
   input  ch_mask_t mask_i,
`ifdef MUX_SEL_SCANNER_REVERSE_EN
   input  logic     dir_i,
`endif
   output sel_t     nxt_o,
   output logic     wrapped_o,
   output logic     any_o
);

   logic     rev;
   ch_mask_t rot;
   sel_t     off;
   sel_t     fwd;
   sel_t     bwd;

`ifdef MUX_SEL_SCANNER_REVERSE_EN
   assign rev = dir_i;
`else
   assign rev = 1'b0;
`endif

   // rot[k] is the channel k+1 steps away from cur in the search direction
   always_comb begin
      rot = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rev)
            rot[k] = mask_i[cur_i - sel_t'(k) - sel_t'(1)];
         else
            rot[k] = mask_i[cur_i + sel_t'(k) + sel_t'(1)];
      end
   end

   // lowest set bit of rot gives the distance to the next eligible channel
   always_comb begin
      off = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (rot[k])
            off = sel_t'(k);
      end
   end

   // map the distance back to a channel index and flag a pass wrap
   always_comb begin
      fwd   = cur_i + off + sel_t'(1);
      bwd   = cur_i - off - sel_t'(1);
      any_o = |mask_i;
      if (!any_o) begin
         nxt_o     = cur_i;
         wrapped_o = 1'b0;
      end else if (rev) begin
         nxt_o     = bwd;
         wrapped_o = (bwd >= cur_i);
      end else begin
         nxt_o     = fwd;
         wrapped_o = (fwd <= cur_i);
      end
   end

endmodule

// File: rtl/mux_sel_scanner.sv
// Channel-select scanner for the downstream 8:1 selector (auto/manual).
// Define MUX_SEL_SCANNER_REVERSE_EN to add the dir input (descending scan).
module mux_sel_scanner
   import mux_sel_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned NUM_CH       = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     enable,
   input  logic     mode,
   input  logic     step,
   input  ch_mask_t mask,
`ifdef MUX_SEL_SCANNER_REVERSE_EN
   input  logic     dir,
`endif
   output sel_t     sel,
   output logic     sel_valid,
   output logic     wrap
);

   localparam int unsigned CNT_W =
      (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(DWELL_CYCLES - 1);

   if (NUM_CH != 8) begin : g_bad_num_ch
      $error("mux_sel_scanner supports only 8 channels");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   sel_t             sel_q, sel_d;
   logic             wrap_q, wrap_d;
   logic             valid_q;
   logic             mode_q;
   logic             adv;
   sel_t             nxt;
   logic             nxt_wrap;
   logic             any;

   mux_sel_next_pick u_pick (
      .cur_i     (sel_q),
      .mask_i    (mask),
`ifdef MUX_SEL_SCANNER_REVERSE_EN
      .dir_i     (dir),
`endif
      .nxt_o     (nxt),
      .wrapped_o (nxt_wrap),
      .any_o     (any)
   );

   // dwell/step control: decide whether this cycle advances the channel
   always_comb begin
      cnt_d = cnt_q;
      adv   = 1'b0;
      if (!enable) begin
         cnt_d = cnt_q;
      end else if (!any) begin
         cnt_d = '0;
      end else if (mode != mode_q) begin
         cnt_d = '0;
      end else if (mode == MODE_MANUAL) begin
         cnt_d = '0;
         adv   = step;
      end else if (cnt_q == TC) begin
         cnt_d = '0;
         adv   = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      sel_d  = adv ? nxt : sel_q;
      wrap_d = adv & nxt_wrap;
   end

   // state registers; rst wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         sel_q   <= '0;
         wrap_q  <= 1'b0;
         valid_q <= 1'b0;
         mode_q  <= MODE_AUTO;
      end else begin
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         wrap_q  <= wrap_d;
         valid_q <= any;
         mode_q  <= mode;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed scoreboard bench for mux_sel_scanner with DWELL_CYCLES = 4.
// Covers MUX_SEL_SCANNER_REVERSE_EN steps when that macro is defined.
module tb_mux_sel_scanner;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       mode;
   logic       step;
   logic [7:0] mask;
`ifdef MUX_SEL_SCANNER_REVERSE_EN
   logic       dir;
`endif
   logic [2:0] sel;
   logic       sel_valid;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp_q[$];

   mux_sel_scanner #(.DWELL_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .mode      (mode),
      .step      (step),
      .mask      (mask),
`ifdef MUX_SEL_SCANNER_REVERSE_EN
      .dir       (dir),
`endif
      .sel       (sel),
      .sel_valid (sel_valid),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int s,
                      input bit v, input bit w);
      logic [4:0] e;
      exp_q.push_back({3'(s), v, w});
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         assert ({sel, sel_valid, wrap} === e) else begin
            errors++;
            $error("FAIL %s: got sel=%0d valid=%0b wrap=%0b, want sel=%0d valid=%0b wrap=%0b",
                   tag, sel, sel_valid, wrap, e[4:2], e[1], e[0]);
         end
      end
   endtask

   initial begin
      int s;
      rst = 1'b1; enable = 1'b1; mode = 1'b0;
      step = 1'b0; mask = 8'hFF;
`ifdef MUX_SEL_SCANNER_REVERSE_EN
      dir = 1'b0;
`endif
      chk("reset", 0, 0, 0);
      chk("reset", 0, 0, 0);

      rst = 1'b0;
      for (int i = 1; i <= 32; i++)
         chk("auto_ff", (i / 4) % 8, 1, i == 32);

      mask = 8'b1010_0100;
      for (int i = 33; i <= 48; i++) begin
         s = (i < 36) ? 0 : (i < 40) ? 2 : (i < 44) ? 5 : (i < 48) ? 7 : 2;
         chk("auto_a4", s, 1, i == 48);
      end

      rst = 1'b1; mode = 1'b1; mask = 8'hFF;
      chk("rst_man", 0, 0, 0);
      rst = 1'b0;
      chk("mode_chg", 0, 1, 0);
      for (int p = 1; p <= 3; p++) begin
         step = 1'b1;
         chk("step", p, 1, 0);
         step = 1'b0;
         chk("hold", p, 1, 0);
         chk("hold", p, 1, 0);
      end

      mode = 1'b0; step = 1'b1;
      chk("step_auto", 3, 1, 0);
      chk("step_auto", 3, 1, 0);
      mode = 1'b1; step = 1'b0;
      chk("back_man", 3, 1, 0);
      enable = 1'b0; step = 1'b1;
      chk("step_dis", 3, 1, 0);
      step = 1'b0;
      chk("dis_hold", 3, 1, 0);
      enable = 1'b1;
      chk("reenable", 3, 1, 0);

      mode = 1'b0; mask = 8'h00;
      for (int i = 0; i < 20; i++)
         chk("mask0", 3, 0, 0);

      mask = 8'h10;
      for (int i = 1; i <= 16; i++)
         chk("single", (i < 4) ? 3 : 4, 1, (i >= 8) && (i % 4 == 0));

      mask = 8'hFF;
      for (int i = 17; i <= 22; i++)
         chk("pre_rst", (i < 20) ? 4 : 5, 1, 0);
      rst = 1'b1;
      chk("mid_rst", 0, 0, 0);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++)
         chk("post_rst", (i < 4) ? 0 : 1, 1, 0);

      mode = 1'b1;
      chk("b2b_chg", 1, 1, 0);
      step = 1'b1;
      chk("b2b", 2, 1, 0);
      chk("b2b", 3, 1, 0);
      step = 1'b0;
      chk("b2b_hold", 3, 1, 0);

`ifdef MUX_SEL_SCANNER_REVERSE_EN
      rst = 1'b1; dir = 1'b1;
      chk("rev_rst", 0, 0, 0);
      rst = 1'b0;
      chk("rev_chg", 0, 1, 0);
      step = 1'b1;
      chk("rev_wrap", 7, 1, 1);
      chk("rev_step", 6, 1, 0);
      step = 1'b0;
      chk("rev_hold", 6, 1, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
